// File: rtl/sal_ref_sched.sv
// Refresh scheduler: counts tREFI, tracks postponed-refresh debt and requests all-bank REF
// over a req/gnt handshake, then holds off for tRFC. Optional macro: SAL_REF_POSTPONE_EN.
module sal_ref_sched #(
   parameter int TREFI_W   = 16,
   parameter int TRFC_W    = 10,
   parameter int MAX_DEBT  = 8,
   parameter int URGENT_TH = 6,
   localparam int DEBT_W   = $clog2(MAX_DEBT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ref_en_i,
   input  logic [TREFI_W-1:0] trefi_i,
   input  logic [TRFC_W-1:0]  trfc_i,
   input  logic               idle_i,
   output logic               ref_req_o,
   output logic               ref_urgent_o,
   input  logic               ref_gnt_i,
   output logic               ref_busy_o,
   output logic [DEBT_W-1:0]  debt_o,
   output logic               overflow_o,
   output logic [1:0]         state_o
);

   // Handshake: ref_req_o rises from IDLE and stays high until the cycle ref_gnt_i is
   // sampled high; a grant seen in any other state is ignored.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RFC  = 2'd2
   } state_t;

   localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);
   localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(URGENT_TH);
   localparam logic [DEBT_W-1:0] DEBT_ONE = DEBT_W'(1);

   state_t              state;
   logic [TREFI_W-1:0]  int_cnt;
   logic [TRFC_W-1:0]   rfc_cnt;
   logic [DEBT_W-1:0]   debt;
   logic [DEBT_W-1:0]   debt_nxt;
   logic                run;
   logic                tick;
   logic                grant;
   logic                debt_ovf;
   logic                want_req;
   logic                urgent_nxt;
   logic [TREFI_W-1:0]  trefi_reload;
   logic [TRFC_W-1:0]   trfc_reload;

   assign run          = ref_en_i && (trefi_i != '0);
   assign tick         = run && (int_cnt == '0);
   assign grant        = (state == ST_REQ) && ref_gnt_i;
   assign trefi_reload = trefi_i - TREFI_W'(1);
   // trfc_i = 0 still gives a one-cycle tRFC window
   assign trfc_reload  = (trfc_i == '0) ? '0 : trfc_i - TRFC_W'(1);

   always_comb begin
      debt_nxt = debt;
      debt_ovf = 1'b0;
      if (tick && !grant) begin
         if (debt == DEBT_MAX) begin
            debt_ovf = 1'b1;
         end else begin
            debt_nxt = debt + DEBT_ONE;
         end
      end else if (grant && !tick) begin
         debt_nxt = debt - DEBT_ONE;
      end
   end

`ifdef SAL_REF_POSTPONE_EN
   assign want_req   = (debt != '0) && (idle_i || (debt >= DEBT_URG));
   assign urgent_nxt = (debt_nxt >= DEBT_URG);
`else
   logic idle_unused;
   assign idle_unused = idle_i;
   assign want_req    = (debt != '0);
   assign urgent_nxt  = 1'b1;
`endif

   // Interval counter: reloads trefi_i-1 on reset, while disabled and after each tick
   always_ff @(posedge clk) begin
      if (rst) begin
         int_cnt <= trefi_reload;
      end else if (!run) begin
         int_cnt <= trefi_reload;
      end else if (int_cnt == '0) begin
         int_cnt <= trefi_reload;
      end else begin
         int_cnt <= int_cnt - TREFI_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         debt       <= '0;
         overflow_o <= 1'b0;
      end else begin
         debt <= debt_nxt;
         if (debt_ovf) begin
            overflow_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         rfc_cnt      <= '0;
         ref_req_o    <= 1'b0;
         ref_urgent_o <= 1'b0;
         ref_busy_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (want_req) begin
                  state        <= ST_REQ;
                  ref_req_o    <= 1'b1;
                  ref_urgent_o <= urgent_nxt;
               end
            end
            ST_REQ: begin
               if (ref_gnt_i) begin
                  state        <= ST_RFC;
                  rfc_cnt      <= trfc_reload;
                  ref_req_o    <= 1'b0;
                  ref_urgent_o <= 1'b0;
                  ref_busy_o   <= 1'b1;
               end else begin
                  ref_urgent_o <= urgent_nxt;
               end
            end
            ST_RFC: begin
               if (rfc_cnt == '0) begin
                  state      <= ST_IDLE;
                  ref_busy_o <= 1'b0;
               end else begin
                  rfc_cnt <= rfc_cnt - TRFC_W'(1);
               end
            end
            default: begin
               state        <= ST_IDLE;
               ref_req_o    <= 1'b0;
               ref_urgent_o <= 1'b0;
               ref_busy_o   <= 1'b0;
            end
         endcase
      end
   end

   assign debt_o  = debt;
   assign state_o = state;

endmodule
